mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter_rr_pick2.sv | 28 ++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Types and defaults shared by the memory port arbiter and the processor
//   datapath that sits in front of it.
//
//   Contents:
//     DEFAULT_DATA_W    - memory word width used by the processor datapath
//     DEFAULT_ADDR_W    - memory word address width (depth = 2**ADDR_W)
//     DEFAULT_MAX_BURST - longest run of locked grants one requester may take
//     NUM_REQ           - number of requesters on the shared port
//     arb_state_t       - arbiter FSM state (IDLE = no burst owner)
//     owner_of()        - helper returning the owning requester of a state
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int DEFAULT_DATA_W    = 16;
  localparam int DEFAULT_ADDR_W    = 3;
  localparam int DEFAULT_MAX_BURST = 4;
  localparam int NUM_REQ           = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Index of the burst owner for an OWNn state; IDLE reports requester 0,
  // callers must qualify the result with "state != IDLE".
  function automatic logic owner_of(input arb_state_t s);
    return (s == OWN1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
//   Two-way round-robin select. A lone request is granted directly; when both
//   requesters ask, the one that was NOT granted last wins.
//
//   Ports:
//     req      [1:0] in   - request vector, bit n = requester n
//     last_gnt       in   - index of the requester granted most recently
//     gnt      [1:0] out  - one-hot grant, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_gnt,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous memory between a processor
//   (requester 0) and a loader/debug port (requester 1). Grants are
//   combinational from the requests and the registered arbiter state, so a
//   request is accepted and issued to the memory in the same cycle. A winner
//   holding lock keeps absolute priority for up to MAX_BURST consecutive
//   grants; after that, or when it releases lock/req, round-robin resumes.
//   Read data returns one cycle after the grant, tagged by rvalid_o.
//
//   Ports:
//     clk, rst_n            in   - clock, asynchronous active-low reset
//     req_i/lock_i/we_i [1:0] in - per-requester request, burst lock, write
//     addr_i  [2*ADDR_W]    in   - per-requester word address (req n at n*ADDR_W)
//     wdata_i [2*DATA_W]    in   - per-requester write data   (req n at n*DATA_W)
//     gnt_o   [1:0]         out  - one-hot or zero, access accepted this cycle
//     rvalid_o[1:0]         out  - read data valid for the named requester
//     rdata_o [DATA_W]      out  - shared read data, zero when rvalid_o == 0
//     mem_en_o/mem_we_o     out  - memory command strobe / write enable
//     mem_addr_o/mem_wdata_o out - memory address / write data
//     mem_rdata_i           in   - memory read data, one cycle after the read
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          lock_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  // Counter must be able to hold MAX_BURST itself.
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic               last_gnt_reg, last_gnt_next;
  logic [NUM_REQ-1:0] rvalid_reg, rvalid_next;

  // -------------------------------------------------------------------------
  // Per-requester views of the packed command buses
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [ADDR_W-1:0] addr_term [NUM_REQ];
  logic [DATA_W-1:0] wdata_term[NUM_REQ];
  logic [NUM_REQ-1:0] we_term;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic               own_valid;
  logic               own_idx;
  logic               hold;
  logic               rr_last;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt_raw;
  logic               win_idx;

  assign own_valid = (state_reg != IDLE);
  assign own_idx   = owner_of(state_reg);

  // The owner keeps the port only while it still asks, still locks, and has
  // burst budget left; otherwise this very cycle falls back to round-robin.
  assign hold = own_valid && req_i[own_idx] && lock_i[own_idx]
                && (burst_cnt_reg < MAX_CNT);

  // Leaving a burst behaves like IDLE with the owner as last winner, so the
  // other side is guaranteed the next tie.
  assign rr_last = own_valid ? own_idx : last_gnt_reg;

  rr_pick2 u_rr_pick2 (
    .req      (req_i),
    .last_gnt (rr_last),
    .gnt      (rr_gnt)
  );

  always_comb begin
    gnt_raw = rr_gnt;
    if (hold) begin
      gnt_raw = own_idx ? 2'b10 : 2'b01;
    end
  end

  // No grant may escape while reset is held, even though requests are live.
  assign gnt_o   = rst_n ? gnt_raw : '0;
  assign win_idx = gnt_o[1];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    last_gnt_next  = last_gnt_reg;

    if (hold) begin
      burst_cnt_next = burst_cnt_reg + ONE_CNT;
      last_gnt_next  = own_idx;
    end else if (|gnt_o) begin
      last_gnt_next = win_idx;
      if (lock_i[win_idx]) begin
        // The grant that opens a burst is itself the first one counted.
        state_next     = win_idx ? OWN1 : OWN0;
        burst_cnt_next = ONE_CNT;
      end else begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end
    end else begin
      state_next     = IDLE;
      burst_cnt_next = '0;
    end
  end

  // Reads return a cycle later; writes never produce a response.
  assign rvalid_next = gnt_o & ~we_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
      last_gnt_reg  <= 1'b0;
      rvalid_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      last_gnt_reg  <= last_gnt_next;
      rvalid_reg    <= rvalid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Memory command mux (AND-OR, idle bus is all zero)
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]   = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = wdata_i[gi*DATA_W +: DATA_W];
      assign addr_term[gi]  = gnt_o[gi] ? addr_arr[gi]  : '0;
      assign wdata_term[gi] = gnt_o[gi] ? wdata_arr[gi] : '0;
      assign we_term[gi]    = gnt_o[gi] & we_i[gi];
    end
  endgenerate

  assign mem_en_o    = |gnt_o;
  assign mem_we_o    = |we_term;
  assign mem_addr_o  = addr_term[0]  | addr_term[1];
  assign mem_wdata_o = wdata_term[0] | wdata_term[1];

  // -------------------------------------------------------------------------
  // Read response
  // -------------------------------------------------------------------------
  assign rvalid_o = rvalid_reg;
  assign rdata_o  = (|rvalid_reg) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with an attached synchronous memory
//   model. Each step drives one cycle of requests, checks the grant and
//   memory command against the expected grant, pushes expected read
//   responses into a scoreboard and pops them when they fall due.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_i, lock_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            mem_en_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW-1:0]   mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [1:0] rv;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_mem [8];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MAX_BURST (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .lock_i      (lock_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  function automatic logic [15:0] preload(input int i);
    return 16'hA000 + 16'(i);
  endfunction

  // Single-port synchronous memory; contents reload while reset is low.
  logic [15:0] mem_model [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem_model[i] <= preload(i);
    end else if (mem_en_o) begin
      if (mem_we_o) mem_model[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata <= mem_model[mem_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reload_shadow();
    for (int i = 0; i < 8; i++) exp_mem[i] = preload(i);
  endtask

  // One arbitration cycle. Called at posedge+1, returns at the next posedge+1.
  task automatic step(input string tag, input logic [1:0] req, input logic [1:0] lock,
                      input logic [1:0] we, input logic [2:0] a0, input logic [2:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] exp_gnt);
    exp_t        e;
    logic        idx;
    logic [2:0]  a;
    req_i   = req;
    lock_i  = lock;
    we_i    = we;
    addr_i  = {a1, a0};
    wdata_i = {d1, d0};
    @(negedge clk);
    // Response side: anything due this cycle, else the port must be quiet.
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check({tag, " rvalid"}, 32'(rvalid_o), 32'(e.rv));
      check({tag, " rdata"},  32'(rdata_o),  32'(e.data));
    end else begin
      check({tag, " rvalid idle"}, 32'(rvalid_o), 32'd0);
      check({tag, " rdata idle"},  32'(rdata_o),  32'd0);
    end
    // Command side.
    check({tag, " gnt"},    32'(gnt_o),    32'(exp_gnt));
    check({tag, " mem_en"}, 32'(mem_en_o), 32'(|exp_gnt));
    if (exp_gnt != 2'b00) begin
      idx = exp_gnt[1];
      a   = idx ? a1 : a0;
      check({tag, " mem_addr"}, 32'(mem_addr_o), 32'(a));
      check({tag, " mem_we"},   32'(mem_we_o),   32'(we[idx]));
      if (we[idx]) begin
        exp_mem[a] = idx ? d1 : d0;
        check({tag, " mem_wdata"}, 32'(mem_wdata_o), 32'(exp_mem[a]));
      end else begin
        sb.push_back('{cyc + 1, exp_gnt, exp_mem[a]});
      end
    end
    $display("cyc=%0d %s req=%b lock=%b we=%b gnt=%b rvalid=%b rdata=%h",
             cyc, tag, req, lock, we, gnt_o, rvalid_o, rdata_o);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_i   = 2'b11;
    lock_i  = 2'b00;
    we_i    = 2'b00;
    addr_i  = '0;
    wdata_i = '0;
    reload_shadow();

    // Reset: requests live but nothing may be granted or returned.
    @(posedge clk);
    @(negedge clk);
    check("reset gnt",    32'(gnt_o),    32'd0);
    check("reset mem_en", 32'(mem_en_o), 32'd0);
    check("reset rvalid", 32'(rvalid_o), 32'd0);
    check("reset rdata",  32'(rdata_o),  32'd0);
    $display("cyc=%0d reset req=%b gnt=%b rvalid=%b", cyc, req_i, gnt_o, rvalid_o);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First tie goes to requester 1, then requester 0; reads return in order.
    step("tie rd1", 2'b11, 2'b00, 2'b00, 3'd3, 3'd5, 16'h0, 16'h0, 2'b10);
    step("rd0",     2'b01, 2'b00, 2'b00, 3'd3, 3'd5, 16'h0, 16'h0, 2'b01);
    step("idle",    2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);
    step("idle",    2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);

    // Write then read the same address in consecutive cycles.
    step("wr0 beef", 2'b01, 2'b00, 2'b01, 3'd2, 3'd0, 16'hBEEF, 16'h0, 2'b01);
    step("rd0 beef", 2'b01, 2'b00, 2'b00, 3'd2, 3'd0, 16'h0,    16'h0, 2'b01);
    step("idle",     2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0,    16'h0, 2'b00);

    // Requester 1 locked burst against a waiting requester 0: 4 grants max.
    step("lock1 c1", 2'b11, 2'b10, 2'b00, 3'd4, 3'd0, 16'h0, 16'h0, 2'b10);
    step("lock1 c2", 2'b11, 2'b10, 2'b00, 3'd4, 3'd1, 16'h0, 16'h0, 2'b10);
    step("lock1 c3", 2'b11, 2'b10, 2'b00, 3'd4, 3'd6, 16'h0, 16'h0, 2'b10);
    step("lock1 c4", 2'b11, 2'b10, 2'b00, 3'd4, 3'd7, 16'h0, 16'h0, 2'b10);
    step("lock1 c5", 2'b11, 2'b10, 2'b00, 3'd4, 3'd7, 16'h0, 16'h0, 2'b01);
    step("lock1 c6", 2'b10, 2'b10, 2'b00, 3'd0, 3'd7, 16'h0, 16'h0, 2'b10);
    step("idle",     2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);

    // Lock released after 2 grants hands the port to the waiting requester 0.
    step("wr0 1234", 2'b01, 2'b00, 2'b01, 3'd6, 3'd0, 16'h1234, 16'h0, 2'b01);
    step("lk1 g1",   2'b11, 2'b10, 2'b00, 3'd4, 3'd2, 16'h0, 16'h0, 2'b10);
    step("lk1 g2",   2'b11, 2'b10, 2'b00, 3'd4, 3'd3, 16'h0, 16'h0, 2'b10);
    step("unlock",   2'b11, 2'b00, 2'b00, 3'd4, 3'd6, 16'h0, 16'h0, 2'b01);
    step("rd1 6",    2'b10, 2'b00, 2'b00, 3'd0, 3'd6, 16'h0, 16'h0, 2'b10);
    step("idle",     2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);

    // Lone locked requester keeps getting grants across the burst limit.
    for (int i = 0; i < 6; i++) begin
      step("lock0 solo", 2'b01, 2'b01, 2'b00, 3'(i), 3'd0, 16'h0, 16'h0, 2'b01);
    end
    step("idle", 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);

    // Reset right after a locked read grant: response is dropped, FSM idles.
    step("lk0 rd", 2'b01, 2'b01, 2'b00, 3'd5, 3'd0, 16'h0, 16'h0, 2'b01);
    rst_n  = 1'b0;
    sb.delete();
    reload_shadow();
    req_i  = 2'b11;
    lock_i = 2'b01;
    @(negedge clk);
    check("midrst gnt",    32'(gnt_o),    32'd0);
    check("midrst mem_en", 32'(mem_en_o), 32'd0);
    check("midrst rvalid", 32'(rvalid_o), 32'd0);
    check("midrst rdata",  32'(rdata_o),  32'd0);
    $display("cyc=%0d midreset req=%b gnt=%b rvalid=%b", cyc, req_i, gnt_o, rvalid_o);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    step("post tie", 2'b11, 2'b00, 2'b00, 3'd3, 3'd7, 16'h0, 16'h0, 2'b10);
    step("post rd0", 2'b01, 2'b00, 2'b00, 3'd3, 3'd7, 16'h0, 16'h0, 2'b01);
    step("idle",     2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);
    step("idle",     2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
